// File: rtl/transpose_stream_ctrl.sv
// transpose_stream_ctrl: buffers one ROWS x COLS matrix arriving row-major and
// streams it back out column-major. LOAD accepts words, DRAIN emits them.
// Optional feature: define TRANSPOSE_STREAM_LAST_EN to add the out_last port,
// which flags the final word of each drained matrix.
module transpose_stream_ctrl #(
  parameter int ROWS = 32,
  parameter int COLS = 10,
  parameter int W    = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
`ifdef TRANSPOSE_STREAM_LAST_EN
  ,
  output logic         out_last
`endif
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  typedef enum logic {LOAD, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] r_q, r_d;   // load row
  logic [CW-1:0] c_q, c_d;   // load column
  logic [RW-1:0] j_q, j_d;   // drain row (fastest)
  logic [CW-1:0] i_q, i_d;   // drain column
  logic          done_q, done_d;
  logic [W-1:0]  mem_q [ROWS][COLS];
  logic          in_fire, out_fire;

  // Handshake outputs decode registered state; reset masks them immediately.
  always_comb begin
    in_ready  = (state_q == LOAD) && !rst;
    out_valid = (state_q == DRAIN) && !rst;
    busy      = !rst && ((state_q == DRAIN) || (r_q != '0) || (c_q != '0));
    done      = done_q && !rst;
    out_data  = mem_q[j_q][i_q];
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
  end

`ifdef TRANSPOSE_STREAM_LAST_EN
  // Final word of the matrix: last column, last row.
  always_comb begin
    out_last = out_valid && (i_q == COL_LAST) && (j_q == ROW_LAST);
  end
`endif

  // Next-state and counter update: load counts c then r, drain counts j then i.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    j_d     = j_q;
    i_d     = i_q;
    done_d  = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (in_fire) begin
          if (c_q == COL_LAST) begin
            c_d = '0;
            if (r_q == ROW_LAST) begin
              r_d     = '0;
              state_d = DRAIN;
            end else begin
              r_d = r_q + 1'b1;
            end
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (j_q == ROW_LAST) begin
            j_d = '0;
            if (i_q == COL_LAST) begin
              i_d     = '0;
              state_d = LOAD;
              done_d  = 1'b1;
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      r_q     <= '0;
      c_q     <= '0;
      j_q     <= '0;
      i_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      j_q     <= j_d;
      i_q     <= i_d;
      done_q  <= done_d;
    end
  end

  // Matrix storage; never reset, only overwritten by accepted words.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_q[r_q][c_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_transpose_stream_ctrl.sv
// Bench for transpose_stream_ctrl: a word-count model of the matrix transpose
// is checked against the DUT every cycle, plus literal expectations per test.
module tb_transpose_stream_ctrl;

  localparam int ROWS = 32;
  localparam int COLS = 10;
  localparam int W    = 32;
  localparam int N    = ROWS * COLS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid, busy, done;
  logic [W-1:0] out_data;
`ifdef TRANSPOSE_STREAM_LAST_EN
  logic         out_last;
`endif

  transpose_stream_ctrl #(.ROWS(ROWS), .COLS(COLS), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
`ifdef TRANSPOSE_STREAM_LAST_EN
    ,
    .out_last  (out_last)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_word(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Model: flat row-major matrix, count of loaded words, count of drained words.
  logic [W-1:0] mat [N];
  int m_ld = 0, m_dr = 0, t_acc = 0;
  bit m_drain = 0, m_done = 0, m_init = 0;

  // Model update on every rising edge from the bench-driven inputs.
  always @(posedge clk) begin
    cyc++;
    m_init = 1;
    if (rst) begin
      m_ld = 0; m_dr = 0; m_drain = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_drain) begin
        if (in_valid) begin
          mat[m_ld] = in_data;
          if (m_ld == N - 1) begin
            m_ld = 0; m_drain = 1; t_acc = cyc;
          end else begin
            m_ld++;
          end
        end
      end else if (out_ready) begin
        if (m_dr == N - 1) begin
          m_dr = 0; m_drain = 0; m_done = 1;
        end else begin
          m_dr++;
        end
      end
    end
  end

  logic [W-1:0] cap [$];
  int done_cnt = 0, t_rise = 0;
  bit prev_stall = 0, prev_valid = 0, ev = 0, pin_last = 0;
  logic [W-1:0] prev_data = '0;

  // Compare process: DUT outputs against the model on each falling edge.
  always @(negedge clk) begin
    if (m_init) begin
      ev = !rst && m_drain;
      check_bit("in_ready", in_ready, !rst && !m_drain);
      check_bit("out_valid", out_valid, ev);
      check_bit("busy", busy, !rst && (m_drain || m_ld != 0));
      check_bit("done", done, !rst && m_done);
      if (ev) check_word("out_data", out_data, mat[(m_dr % ROWS) * COLS + m_dr / ROWS]);
      if (ev && prev_stall) check_word("stall_hold", out_data, prev_data);
      if (out_valid === 1'b1 && !prev_valid) t_rise = cyc;
      if (done === 1'b1) begin
        done_cnt++;
        check_bit("done_in_ready", in_ready, 1'b1);
      end
      if (out_valid === 1'b1 && out_ready) cap.push_back(out_data);
`ifdef TRANSPOSE_STREAM_LAST_EN
      check_bit("out_last", out_last, ev && m_dr == N - 1);
      if (out_last === 1'b1 && pin_last) check_word("last_value", out_data, 32'h0000_1F09);
`endif
      prev_stall = ev && !out_ready;
      prev_data  = out_data;
      prev_valid = (out_valid === 1'b1);
    end
  end

  bit stall_mode = 0;
  int last_hold = 0;

  // Output-side stall generator, with a forced stall on the final word.
  initial forever begin
    @(posedge clk); #1;
    if (stall_mode) begin
      if (m_drain && m_dr == N - 1 && last_hold < 3) begin
        out_ready = 1'b0;
        last_hold++;
      end else begin
        out_ready = ($urandom_range(0, 2) != 0);
      end
    end else begin
      out_ready = 1'b1;
    end
  end

  logic [W-1:0] words [2*N];

  task automatic fill_pattern();
    for (int k = 0; k < N; k++) words[k] = 32'h100 * (k / COLS) + (k % COLS);
  endtask

  task automatic fill_random();
    for (int k = 0; k < 2 * N; k++) words[k] = $urandom;
  endtask

  // Drives n words; gaps inserts random idle cycles, garbage pushes in_valid during drain.
  task automatic load(input int n, input bit gaps, input bit garbage);
    int idx = 0;
    int guard = 0;
    bit take;
    while (idx < n && guard < 20000) begin
      if (m_drain) begin
        in_valid = garbage; in_data = $urandom;
      end else if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; in_data = $urandom;
      end else begin
        in_valid = 1'b1; in_data = words[idx];
      end
      take = in_valid && !m_drain;
      @(posedge clk); #1;
      if (take) idx++;
      guard++;
    end
    in_valid = 1'b0;
    check_bit("load_timeout", guard < 20000, 1'b1);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((m_drain || m_ld != 0) && g < 5000) begin
      @(posedge clk); #1;
      g++;
    end
    check_bit("idle_timeout", g < 5000, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic check_cap(input int nmat);
    int k2;
    check_int("cap_len", cap.size(), nmat * N);
    for (int m = 0; m < nmat; m++) begin
      for (int k = 0; k < N; k++) begin
        k2 = m * N + k;
        if (k2 < cap.size())
          check_word("seq", cap[k2], words[m * N + (k % ROWS) * COLS + k / ROWS]);
      end
    end
  endtask

  initial begin
    int g;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Test 1: continuous load, no stalls, indexed pattern.
    fill_pattern();
    pin_last = 1; stall_mode = 0; done_cnt = 0; cap.delete();
    load(N, 0, 0);
    wait_idle();
    check_cap(1);
    if (cap.size() == N) begin
      check_word("first_0", cap[0], 32'h0000_0000);
      check_word("first_1", cap[1], 32'h0000_0100);
      check_word("k31", cap[31], 32'h0000_1F00);
      check_word("k32", cap[32], 32'h0000_0001);
      check_word("last", cap[N-1], 32'h0000_1F09);
    end
    check_int("latency", t_rise, t_acc);
    check_int("done_count_1", done_cnt, 1);

    // Test 2: same matrix with input gaps, output stalls and drain-time garbage.
    stall_mode = 1; last_hold = 0; cap.delete();
    load(N, 1, 1);
    wait_idle();
    check_cap(1);
    stall_mode = 0; pin_last = 0;

    // Test 3: reset mid-load and mid-drain, then a fresh matrix.
    fill_random();
    load(150, 1, 0);
    @(negedge clk);
    check_bit("busy_partial", busy, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_bit("busy_after_rst", busy, 1'b0);
    check_bit("ready_after_rst", in_ready, 1'b1);
    @(posedge clk); #1;
    fill_random();
    stall_mode = 1; last_hold = 0;
    load(N, 1, 0);
    g = 0;
    while (m_dr < 40 && g < 2000) begin @(posedge clk); #1; g++; end
    check_bit("drain_timeout", g < 2000, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    fill_random();
    last_hold = 0; cap.delete();
    load(N, 1, 1);
    wait_idle();
    check_cap(1);

    // Test 4: two matrices back-to-back with garbage offered during drain.
    stall_mode = 0; done_cnt = 0; cap.delete();
    fill_random();
    load(2 * N, 0, 1);
    wait_idle();
    check_cap(2);
    check_int("done_count_2", done_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/transpose_stream_ctrl.md
TRANSPOSE_STREAM_CTRL -- requirements
Module: transpose_stream_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 32, meaning rows of the input matrix.
REQ-002 SHALL have parameter COLS, default 10, meaning columns of the input matrix.
REQ-003 SHALL have parameter W, default 32, meaning signed word width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_data  input  W  input matrix word, row-major order.
REQ-007 SHALL have port in_valid  input  1  in_data is valid.
REQ-008 SHALL have port in_ready  output  1  block accepts an input word.
REQ-009 SHALL have port out_data  output  W  transposed matrix word, column-major order.
REQ-010 SHALL have port out_valid  output  1  out_data is valid.
REQ-011 SHALL have port out_ready  input  1  sink accepts an output word.
REQ-012 SHALL have port busy  output  1  a matrix is partially loaded or draining.
REQ-013 SHALL have port done  output  1  one-cycle pulse after the final output transfer.

Function
REQ-014 SHALL implement two states: LOAD and DRAIN. LOAD is the reset state.
REQ-015 SHALL drive in_ready = 1 only in LOAD and out_valid = 1 only in DRAIN, both decoded from registered state.
REQ-016 SHALL accept an input word only when in_valid && in_ready, and write it to buf[r][c]. The column counter c (width clog2(COLS)) increments first, wrapping at COLS-1 and then incrementing row counter r (width clog2(ROWS)).
REQ-017 SHALL move from LOAD to DRAIN on the clock edge accepting word ROWS*COLS-1 (r=ROWS-1, c=COLS-1) and clear both counters. out_valid SHALL be 1 on the very next cycle, giving a latency of 1 cycle.
REQ-018 In DRAIN, SHALL present out_data = buf[j][i]. Row index j increments fastest (0..ROWS-1), then column index i (0..COLS-1); output k = i*ROWS + j.
REQ-019 SHALL advance the drain counters only on out_valid && out_ready. out_data SHALL stay stable while out_valid && !out_ready.
REQ-020 SHALL return to LOAD, with counters cleared, on the transfer of the last word (i=COLS-1, j=ROWS-1), and SHALL pulse done = 1 for exactly the following cycle.
REQ-021 SHALL ignore in_valid in DRAIN and out_ready in LOAD. Input stalls (in_valid = 0) and output stalls (out_ready = 0) of any length SHALL NOT corrupt the counters.
REQ-022 SHALL drive busy = 1 in DRAIN, and in LOAD when at least one word of the current matrix has been accepted; otherwise busy = 0.
REQ-023 SHALL allow back-to-back matrices: in_ready = 1 on the cycle done pulses.
REQ-024 SHALL store data unmodified: no sign extension and no arithmetic on data words.

Reset
REQ-025 While rst = 1, SHALL force state = LOAD, all counters = 0, in_ready = 0, out_valid = 0, busy = 0 and done = 0.
REQ-026 Reset mid-LOAD or mid-DRAIN SHALL discard the partial matrix; in_ready = 1 on the first cycle after rst falls.
REQ-027 The buffer contents SHALL NOT be reset; stale contents are never output before a full reload.

Configuration
REQ-028 With macro TRANSPOSE_STREAM_LAST_EN defined:
- SHALL add port out_last  output  1, which is 1 together with out_valid on the final word of a matrix (i=COLS-1, j=ROWS-1) and 0 otherwise, including during reset.
REQ-029 Without TRANSPOSE_STREAM_LAST_EN, the out_last port and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-030 Load in_data = 0x100*r + c with continuous in_valid and out_ready held 1 -> first outputs are 0x000, 0x100, ... 0x1F00, then 0x001, and the last output is 0x1F09; out_valid rises 1 cycle after input 320.
REQ-031 Random in_valid gaps and random out_ready stalls on the same matrix -> identical 320-word output sequence; out_data holds during every stall.
REQ-032 Assert rst after 150 inputs, then load a full new matrix -> only the new matrix is output; busy = 0 immediately after reset.
REQ-033 Two matrices back-to-back -> done pulses once per matrix, exactly 1 cycle after output 320; in_ready = 1 in that same cycle.
REQ-034 Drive in_valid = 1 during DRAIN with garbage data -> no word accepted; the output sequence is unaffected.
REQ-035 With TRANSPOSE_STREAM_LAST_EN defined -> out_last = 1 only alongside value 0x1F09, and is held through an out_ready stall on that word.
